// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives imem req/ack, fills IF/ID. Optional FETCH_PERF_EN adds perf counters.
// Latency: ack at edge n -> IF/ID in cycle n+1. Stall parks one fetched word in a skid buffer and drops imem_req.
module fetch_stage #(
  parameter int                      ADDR_WIDTH  = 16,
  parameter int                      INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [3:0]             if_id_opcode,
  output logic [ADDR_WIDTH-1:0]  pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  pc_nxt;
  logic [ADDR_WIDTH-1:0]  drain_addr, drain_addr_nxt;
  logic [INSTR_WIDTH-1:0] buf_instr, buf_instr_nxt;
  logic [ADDR_WIDTH-1:0]  buf_pc, buf_pc_nxt;
  logic                   if_id_valid_nxt;
  logic [INSTR_WIDTH-1:0] if_id_instr_nxt;
  logic [ADDR_WIDTH-1:0]  if_id_pc_nxt;

  // DRAIN keeps presenting the pre-flush address so the outstanding request completes unchanged.
  assign imem_req     = (state != S_HOLD);
  assign imem_addr    = (state == S_DRAIN) ? drain_addr : pc;
  assign if_id_opcode = if_id_instr[INSTR_WIDTH-1 -: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      drain_addr  <= '0;
      buf_instr   <= NOP_INSTR;
      buf_pc      <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drain_addr  <= drain_addr_nxt;
      buf_instr   <= buf_instr_nxt;
      buf_pc      <= buf_pc_nxt;
      if_id_valid <= if_id_valid_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_pc    <= if_id_pc_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    drain_addr_nxt  = drain_addr;
    buf_instr_nxt   = buf_instr;
    buf_pc_nxt      = buf_pc;
    if_id_valid_nxt = if_id_valid;
    if_id_instr_nxt = if_id_instr;
    if_id_pc_nxt    = if_id_pc;

    if (flush) begin
      // Flush beats stall: bubble IF/ID, drop the skid entry, retarget the PC.
      if_id_valid_nxt = 1'b0;
      if_id_instr_nxt = NOP_INSTR;
      buf_instr_nxt   = NOP_INSTR;
      buf_pc_nxt      = '0;
      pc_nxt          = redirect_pc;
      case (state)
        S_REQ: begin
          if (!imem_ack) begin
            state_nxt      = S_DRAIN;
            drain_addr_nxt = pc;
          end
        end
        S_HOLD:  state_nxt = S_REQ;
        S_DRAIN: if (imem_ack) state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            pc_nxt = pc + ADDR_WIDTH'(1);
            if (stall) begin
              buf_instr_nxt = imem_rdata;
              buf_pc_nxt    = pc;
              state_nxt     = S_HOLD;
            end else begin
              if_id_valid_nxt = 1'b1;
              if_id_instr_nxt = imem_rdata;
              if_id_pc_nxt    = pc;
            end
          end else if (!stall) begin
            if_id_valid_nxt = 1'b0;
            if_id_instr_nxt = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_id_valid_nxt = 1'b1;
            if_id_instr_nxt = buf_instr;
            if_id_pc_nxt    = buf_pc;
            buf_instr_nxt   = NOP_INSTR;
            buf_pc_nxt      = '0;
            state_nxt       = S_REQ;
          end
        end
        S_DRAIN: begin
          // The stale word is thrown away; IF/ID keeps bubbling until real fetch resumes.
          if (imem_ack) state_nxt = S_REQ;
          if (!stall) begin
            if_id_valid_nxt = 1'b0;
            if_id_instr_nxt = NOP_INSTR;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic valid_load;
  logic bubble_load;

  assign valid_load  = !flush && !stall &&
                       (((state == S_REQ) && imem_ack) || (state == S_HOLD));
  assign bubble_load = flush ||
                       (!stall && (((state == S_REQ) && !imem_ack) || (state == S_DRAIN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (valid_load)  perf_fetched <= perf_fetched + 32'd1;
      if (bubble_load) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a transaction-level model predicts the delivered instruction stream.
module tb_fetch_stage;

  localparam int AW = 16;
  localparam int IW = 16;
  localparam logic [IW-1:0] NOP = 16'h0000;

  logic          clk = 1'b0;
  logic          reset, stall, flush, imem_ack;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          if_id_valid;
  logic [IW-1:0] if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic [3:0]    if_id_opcode;
  logic [AW-1:0] pc;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_bubbles;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_opcode(if_id_opcode), .pc(pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  // Instruction memory contents as a pure function of address.
  function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
    case (a)
      16'h0000: memf = 16'h1234;
      16'h0001: memf = 16'h3ABC;
      16'h0002: memf = 16'hD005;
      default:  memf = (a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  assign imem_rdata = memf(imem_addr);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } item_t;

  item_t         exp_q[$];
  logic [AW-1:0] m_pc, m_sq_addr;
  bit            m_held, m_squash, m_rst, m_flushed, may_load, started;
  item_t         m_skid;
  int unsigned   m_fetched, m_bubbles;
  int            passed, total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  // Spec-level model: next sequential address, an optional parked word, an optional abandoned request.
  task automatic model_step();
    item_t it;
    bit    pushed;
    pushed    = 0;
    started   = 1;
    m_flushed = 0;
    if (reset) begin
      m_pc = 16'h0000; m_held = 0; m_squash = 0; m_rst = 1; may_load = 0;
      m_fetched = 0; m_bubbles = 0;
      exp_q.delete();
    end else begin
      m_rst    = 0;
      may_load = !flush && !stall;
      if (flush) begin
        m_flushed = 1;
        if (m_held) m_held = 0;
        else if (m_squash) begin
          if (imem_ack) m_squash = 0;
        end else if (!imem_ack) begin
          m_squash  = 1;
          m_sq_addr = m_pc;
        end
        m_pc = redirect_pc;
      end else if (m_held) begin
        if (!stall) begin
          exp_q.push_back(m_skid);
          pushed = 1;
          m_held = 0;
        end
      end else if (m_squash) begin
        if (imem_ack) m_squash = 0;
      end else if (imem_ack) begin
        it.pc    = m_pc;
        it.instr = memf(m_pc);
        m_pc     = m_pc + 16'd1;
        if (stall) begin
          m_held = 1;
          m_skid = it;
        end else begin
          exp_q.push_back(it);
          pushed = 1;
        end
      end
      if (pushed) m_fetched++;
      if (flush || (!stall && !pushed)) m_bubbles++;
    end
  endtask

  task automatic cycle(input bit rst, input bit ack, input bit stl, input bit fl, input logic [AW-1:0] rpc);
    reset = rst; imem_ack = ack; stall = stl; flush = fl; redirect_pc = rpc;
    @(posedge clk);
    model_step();
    #2;
  endtask

  // Monitor: compares DUT state against the model and pops the scoreboard on every IF/ID load.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("pc", pc, m_pc);
        chk("imem_req", imem_req, !m_held);
        if (!m_held) chk("imem_addr", imem_addr, m_squash ? m_sq_addr : m_pc);
        if (m_rst) begin
          chk("rst_valid", if_id_valid, 1'b0);
          chk("rst_instr", if_id_instr, NOP);
          chk("rst_ifid_pc", if_id_pc, 16'h0000);
        end else if (m_flushed) begin
          chk("flush_valid", if_id_valid, 1'b0);
          chk("flush_instr", if_id_instr, NOP);
        end else if (may_load && if_id_valid) begin
          if (exp_q.size() == 0) chk("spurious_load", if_id_valid, 1'b0);
          else begin
            it = exp_q.pop_front();
            chk("ifid_pc", if_id_pc, it.pc);
            chk("ifid_instr", if_id_instr, it.instr);
            chk("ifid_opcode", if_id_opcode, it.instr[IW-1 -: 4]);
          end
        end else if (exp_q.size() != 0) begin
          it = exp_q.pop_front();
          chk("missing_load", if_id_valid, 1'b1);
        end else if (may_load) begin
          chk("bubble_instr", if_id_instr, NOP);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
      end
    end
  end

  initial begin
    reset = 1; stall = 0; flush = 0; imem_ack = 0; redirect_pc = '0;
    started = 0; passed = 0; total = 0;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);         // pc 0..3 zero-wait
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);         // pc 4 waits 3 cycles
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);         // pc 4,5,6
    cycle(0, 1, 1, 0, 0);                                     // pc 7 acked under stall
    cycle(0, 1, 1, 0, 0);                                     // ack ignored while parked
    cycle(0, 0, 0, 0, 0);                                     // release pc 7
    cycle(0, 1, 0, 0, 0);                                     // pc 8
    cycle(0, 0, 0, 1, 16'h0020);                              // flush while pc 9 waits
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);                                     // stale ack discarded
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);                                     // park a word
    cycle(0, 0, 1, 1, 16'h0040);                              // flush + stall while parked
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 16'h0100);                              // flush into drain
    cycle(0, 0, 0, 1, 16'h0200);                              // newer redirect while draining
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 16'hFFFE);                              // flush with ack
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);         // wrap past 0xFFFF
    cycle(1, 1, 0, 0, 0);                                     // reset mid-run
    for (int i = 0; i < 4000; i++) begin
      bit            r, f, s, a;
      logic [AW-1:0] rp;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 9) < 6);
      rp = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + 16'($urandom_range(0, 3)))
                                       : AW'($urandom);
      cycle(r, a, s, f, rp);
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
